alu_operand_stage: RTL and testbench

Registered operand-delivery stage directly upstream of the 32-bit ALU. Accepts decoded operations over a valid/ready handshake and selects register or sign-extended immediate for operand B. Applies write-back forwarding and presents stable `A`, `B` and `F` to the ALU from a 2-entry skid buffer, so back-pressure from execute never drops or corrupts an operation.

---
 rtl/nachi_alu_pkg.sv | 42 ++++
 rtl/alu_operand_stage_if.sv | 43 ++++
 rtl/operand_fwd.sv | 20 ++
 rtl/alu_operand_stage.sv | 172 +++++++++++++++++
 tb/tb_alu_operand_stage.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/nachi_alu_pkg.sv
// Shared types and constants for the ALU operand-delivery stage.
// Optional build macro: ALU_OPERAND_FWD_EN (adds rs/rt to the held entry).
package nachi_alu_pkg;

  localparam int unsigned ALU_N   = 32;
  localparam int unsigned REG_W   = 5;
  localparam int unsigned IMM_W   = 16;
  localparam int unsigned FN_W    = 3;
  localparam int unsigned STALL_W = 16;

  localparam logic [FN_W-1:0] ALU_F_AND = 3'b000;
  localparam logic [FN_W-1:0] ALU_F_OR  = 3'b001;
  localparam logic [FN_W-1:0] ALU_F_ADD = 3'b010;
  localparam logic [FN_W-1:0] ALU_F_SUB = 3'b110;
  localparam logic [FN_W-1:0] ALU_F_SLT = 3'b111;

  // Occupancy of the MAIN/SKID pair
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } opstage_state_t;

  // One held operation
  typedef struct packed {
    logic [ALU_N-1:0] a;
    logic [ALU_N-1:0] b;
    logic [FN_W-1:0]  f;
    logic [REG_W-1:0] rd;
`ifdef ALU_OPERAND_FWD_EN
    logic [REG_W-1:0] rs;
    logic [REG_W-1:0] rt;
`endif
    logic             use_imm;
  } op_entry_t;

  // Sign-extend a 16-bit immediate to datapath width
  function automatic logic [ALU_N-1:0] sext_imm(input logic [IMM_W-1:0] imm);
    return {{(ALU_N-IMM_W){imm[IMM_W-1]}}, imm};
  endfunction

endpackage

// File: rtl/alu_operand_stage_if.sv
// Upstream, write-back and ALU-side signals of the operand stage.
interface alu_operand_stage_if
  import nachi_alu_pkg::*;
#(
  parameter int unsigned N = ALU_N
);

  logic              in_valid;
  logic              in_ready;
  logic [N-1:0]      in_rs_data;
  logic [N-1:0]      in_rt_data;
  logic [REG_W-1:0]  in_rs;
  logic [REG_W-1:0]  in_rt;
  logic [IMM_W-1:0]  in_imm;
  logic              in_use_imm;
  logic [FN_W-1:0]   in_alu_f;
  logic [REG_W-1:0]  in_rd;
  logic              wb_en;
  logic [REG_W-1:0]  wb_rd;
  logic [N-1:0]      wb_data;
  logic              out_valid;
  logic              out_ready;
  logic [N-1:0]      alu_a;
  logic [N-1:0]      alu_b;
  logic [FN_W-1:0]   alu_f;
  logic [REG_W-1:0]  out_rd;
  logic [STALL_W-1:0] stall_cnt;

  // Stage side
  modport slave (
    input  in_valid, in_rs_data, in_rt_data, in_rs, in_rt, in_imm, in_use_imm,
           in_alu_f, in_rd, wb_en, wb_rd, wb_data, out_ready,
    output in_ready, out_valid, alu_a, alu_b, alu_f, out_rd, stall_cnt
  );

  // Decode / execute side
  modport master (
    output in_valid, in_rs_data, in_rt_data, in_rs, in_rt, in_imm, in_use_imm,
           in_alu_f, in_rd, wb_en, wb_rd, wb_data, out_ready,
    input  in_ready, out_valid, alu_a, alu_b, alu_f, out_rd, stall_cnt
  );

endinterface

// File: rtl/operand_fwd.sv
// Write-back bypass for one operand: wb_data wins on a non-zero register match.
module operand_fwd
  import nachi_alu_pkg::*;
#(
  parameter int unsigned W = ALU_N
) (
  input  logic [REG_W-1:0] i_reg,
  input  logic [W-1:0]     i_value,
  input  logic             i_wb_en,
  input  logic [REG_W-1:0] i_wb_rd,
  input  logic [W-1:0]     i_wb_data,
  output logic [W-1:0]     o_value_c
);

  logic w_hit;

  assign w_hit     = i_wb_en & (i_wb_rd != '0) & (i_wb_rd == i_reg);
  assign o_value_c = w_hit ? i_wb_data : i_value;

endmodule

// File: rtl/alu_operand_stage.sv
// Registered operand stage feeding the ALU through a 2-entry skid buffer.
// Optional build macro: ALU_OPERAND_FWD_EN enables write-back forwarding.
module alu_operand_stage
  import nachi_alu_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  alu_operand_stage_if.slave  bus
);

  opstage_state_t     r_state;
  opstage_state_t     w_state_nxt;
  op_entry_t          r_main;
  op_entry_t          r_skid;
  op_entry_t          w_in_raw;
  op_entry_t          w_in_entry;
  op_entry_t          w_main_cur;
  op_entry_t          w_skid_cur;
  op_entry_t          w_main_nxt;
  op_entry_t          w_skid_nxt;
  logic               w_in_ready;
  logic               w_out_valid;
  logic               w_accept;
  logic               w_consume;
  logic [STALL_W-1:0] r_stall_cnt;

  // Capture of the incoming operation before any bypass
  always_comb begin
    w_in_raw         = '0;
    w_in_raw.a       = bus.in_rs_data;
    w_in_raw.b       = bus.in_use_imm ? sext_imm(bus.in_imm) : bus.in_rt_data;
    w_in_raw.f       = bus.in_alu_f;
    w_in_raw.rd      = bus.in_rd;
`ifdef ALU_OPERAND_FWD_EN
    w_in_raw.rs      = bus.in_rs;
    w_in_raw.rt      = bus.in_rt;
`endif
    w_in_raw.use_imm = bus.in_use_imm;
  end

`ifdef ALU_OPERAND_FWD_EN
  logic [ALU_N-1:0] w_in_a_fwd;
  logic [ALU_N-1:0] w_in_b_fwd;
  logic [ALU_N-1:0] w_main_a_fwd;
  logic [ALU_N-1:0] w_main_b_fwd;
  logic [ALU_N-1:0] w_skid_a_fwd;
  logic [ALU_N-1:0] w_skid_b_fwd;

  // Immediate B operands never take the bypass
  operand_fwd #(.W(ALU_N)) u_fwd_in_a (
    .i_reg(w_in_raw.rs), .i_value(w_in_raw.a), .i_wb_en(bus.wb_en),
    .i_wb_rd(bus.wb_rd), .i_wb_data(bus.wb_data), .o_value_c(w_in_a_fwd));
  operand_fwd #(.W(ALU_N)) u_fwd_in_b (
    .i_reg(w_in_raw.rt), .i_value(w_in_raw.b), .i_wb_en(bus.wb_en & ~w_in_raw.use_imm),
    .i_wb_rd(bus.wb_rd), .i_wb_data(bus.wb_data), .o_value_c(w_in_b_fwd));
  operand_fwd #(.W(ALU_N)) u_fwd_main_a (
    .i_reg(r_main.rs), .i_value(r_main.a), .i_wb_en(bus.wb_en),
    .i_wb_rd(bus.wb_rd), .i_wb_data(bus.wb_data), .o_value_c(w_main_a_fwd));
  operand_fwd #(.W(ALU_N)) u_fwd_main_b (
    .i_reg(r_main.rt), .i_value(r_main.b), .i_wb_en(bus.wb_en & ~r_main.use_imm),
    .i_wb_rd(bus.wb_rd), .i_wb_data(bus.wb_data), .o_value_c(w_main_b_fwd));
  operand_fwd #(.W(ALU_N)) u_fwd_skid_a (
    .i_reg(r_skid.rs), .i_value(r_skid.a), .i_wb_en(bus.wb_en),
    .i_wb_rd(bus.wb_rd), .i_wb_data(bus.wb_data), .o_value_c(w_skid_a_fwd));
  operand_fwd #(.W(ALU_N)) u_fwd_skid_b (
    .i_reg(r_skid.rt), .i_value(r_skid.b), .i_wb_en(bus.wb_en & ~r_skid.use_imm),
    .i_wb_rd(bus.wb_rd), .i_wb_data(bus.wb_data), .o_value_c(w_skid_b_fwd));

  // Reassemble entries with bypassed operands
  always_comb begin
    w_in_entry   = w_in_raw;
    w_in_entry.a = w_in_a_fwd;
    w_in_entry.b = w_in_b_fwd;
    w_main_cur   = r_main;
    w_main_cur.a = w_main_a_fwd;
    w_main_cur.b = w_main_b_fwd;
    w_skid_cur   = r_skid;
    w_skid_cur.a = w_skid_a_fwd;
    w_skid_cur.b = w_skid_b_fwd;
  end
`else
  logic w_unused;

  // Without forwarding the write-back port and source numbers are ignored
  assign w_unused   = ^{bus.in_rs, bus.in_rt, bus.wb_en, bus.wb_rd, bus.wb_data};
  assign w_in_entry = w_in_raw;
  assign w_main_cur = r_main;
  assign w_skid_cur = r_skid;
`endif

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_EMPTY;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_EMPTY: if (w_accept) w_state_nxt = ST_ONE;
      ST_ONE: begin
        if (w_accept && !w_consume)      w_state_nxt = ST_TWO;
        else if (!w_accept && w_consume) w_state_nxt = ST_EMPTY;
      end
      ST_TWO:   if (w_consume) w_state_nxt = ST_ONE;
      default:  w_state_nxt = ST_EMPTY;
    endcase
  end

  // Handshake outputs decoded from registered state only
  always_comb begin
    w_in_ready  = 1'b1;
    w_out_valid = 1'b0;
    unique case (r_state)
      ST_EMPTY: ;
      ST_ONE:   w_out_valid = 1'b1;
      ST_TWO: begin
        w_in_ready  = 1'b0;
        w_out_valid = 1'b1;
      end
      default: ;
    endcase
  end

  assign w_accept  = bus.in_valid & w_in_ready;
  assign w_consume = w_out_valid & bus.out_ready;

  // Entry steering; held entries always carry their bypassed values forward
  always_comb begin
    w_main_nxt = w_main_cur;
    w_skid_nxt = w_skid_cur;
    if (w_accept && ((r_state == ST_EMPTY) || w_consume)) begin
      w_main_nxt = w_in_entry;
    end else if ((r_state == ST_TWO) && w_consume) begin
      w_main_nxt = w_skid_cur;
    end
    if ((r_state == ST_ONE) && w_accept && !w_consume) begin
      w_skid_nxt = w_in_entry;
    end
  end

  // Entry registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_main   <= '0;
      r_main.f <= ALU_F_AND;
      r_skid   <= '0;
    end else begin
      r_main <= w_main_nxt;
      r_skid <= w_skid_nxt;
    end
  end

  // Saturating count of cycles the ALU holds off a valid operation
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stall_cnt <= '0;
    end else if (w_out_valid && !bus.out_ready && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + STALL_W'(1);
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.alu_a     = r_main.a;
  assign bus.alu_b     = r_main.b;
  assign bus.alu_f     = r_main.f;
  assign bus.out_rd    = r_main.rd;
  assign bus.stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Randomised and directed check of alu_operand_stage against a 2-deep FIFO model.
module tb_alu_operand_stage;
  import nachi_alu_pkg::*;

  localparam int unsigned N = ALU_N;

`ifdef ALU_OPERAND_FWD_EN
  localparam logic [31:0] EXP_FWD_A  = 32'hDEADBEEF;
  localparam logic [31:0] EXP_SKID_A = 32'hCAFEF00D;
`else
  localparam logic [31:0] EXP_FWD_A  = 32'h0000_0005;
  localparam logic [31:0] EXP_SKID_A = 32'h0000_0001;
`endif

  localparam logic [31:0] STR_A [4] = '{32'd5, 32'd9, 32'h0000_00F0, 32'hFFFF_FFFF};
  localparam logic [31:0] STR_B [4] = '{32'd7, 32'd3, 32'h0000_000F, 32'd1};
  localparam logic [2:0]  STR_F [4] = '{ALU_F_ADD, ALU_F_SUB, ALU_F_OR, ALU_F_SLT};

  typedef struct {
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [2:0]   f;
    logic [4:0]   rd;
    logic [4:0]   rs;
    logic [4:0]   rt;
    logic         use_imm;
  } mop_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  mop_t        mq[$];
  int unsigned m_stall = 0;
  int          n_vec = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  alu_operand_stage_if #(.N(N)) bus ();

  alu_operand_stage dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check_val(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Bypass a write-back value into a model entry
  function automatic mop_t model_fwd(input mop_t e);
    mop_t r;
    r = e;
`ifdef ALU_OPERAND_FWD_EN
    if (bus.wb_en && (bus.wb_rd != 5'd0)) begin
      if (e.rs == bus.wb_rd) r.a = bus.wb_data;
      if (!e.use_imm && (e.rt == bus.wb_rd)) r.b = bus.wb_data;
    end
`endif
    return r;
  endfunction

  // Model of one rising edge: FIFO with room for two
  task automatic model_edge();
    logic con, acc;
    mop_t e;
    con = (mq.size() > 0) && bus.out_ready;
    acc = bus.in_valid && (mq.size() < 2);
    if ((mq.size() > 0) && !bus.out_ready && (m_stall < 32'hFFFF)) m_stall++;
    foreach (mq[i]) mq[i] = model_fwd(mq[i]);
    if (con) void'(mq.pop_front());
    if (acc) begin
      e.a       = bus.in_rs_data;
      e.b       = bus.in_use_imm ? N'(signed'(bus.in_imm)) : bus.in_rt_data;
      e.f       = bus.in_alu_f;
      e.rd      = bus.in_rd;
      e.rs      = bus.in_rs;
      e.rt      = bus.in_rt;
      e.use_imm = bus.in_use_imm;
      mq.push_back(model_fwd(e));
    end
  endtask

  task automatic check_outputs();
    check_val("in_ready", N'(bus.in_ready), N'(mq.size() < 2));
    check_val("out_valid", N'(bus.out_valid), N'(mq.size() > 0));
    if (mq.size() > 0) begin
      check_val("alu_a", bus.alu_a, mq[0].a);
      check_val("alu_b", bus.alu_b, mq[0].b);
      check_val("alu_f", N'(bus.alu_f), N'(mq[0].f));
      check_val("out_rd", N'(bus.out_rd), N'(mq[0].rd));
    end
    check_val("stall_cnt", N'(bus.stall_cnt), N'(m_stall));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic drive_op(input logic [N-1:0] rsd, input logic [N-1:0] rtd,
                          input logic [4:0] rs, input logic [4:0] rt,
                          input logic [15:0] imm, input logic ui,
                          input logic [2:0] f, input logic [4:0] rd);
    bus.in_valid   = 1'b1;
    bus.in_rs_data = rsd;
    bus.in_rt_data = rtd;
    bus.in_rs      = rs;
    bus.in_rt      = rt;
    bus.in_imm     = imm;
    bus.in_use_imm = ui;
    bus.in_alu_f   = f;
    bus.in_rd      = rd;
  endtask

  task automatic set_wb(input logic en, input logic [4:0] rd, input logic [N-1:0] data);
    bus.wb_en   = en;
    bus.wb_rd   = rd;
    bus.wb_data = data;
  endtask

  // Reset asserted between edges; outputs must clear without waiting for a clock
  task automatic async_reset();
    #2 reset = 1'b1;
    #1;
    check_val("rst_in_ready", N'(bus.in_ready), N'(1));
    check_val("rst_out_valid", N'(bus.out_valid), N'(0));
    check_val("rst_alu_f", N'(bus.alu_f), N'(ALU_F_AND));
    check_val("rst_alu_a", bus.alu_a, '0);
    check_val("rst_alu_b", bus.alu_b, '0);
    check_val("rst_out_rd", N'(bus.out_rd), N'(0));
    check_val("rst_stall", N'(bus.stall_cnt), N'(0));
    mq.delete();
    m_stall = 0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    drive_op('0, '0, 5'd0, 5'd0, 16'd0, 1'b0, ALU_F_AND, 5'd0);
    bus.in_valid  = 1'b0;
    set_wb(1'b0, 5'd0, '0);
    async_reset();

    // Streaming: one op per cycle, each visible right after its accept edge
    for (int i = 0; i < 4; i++) begin
      drive_op(STR_A[i], STR_B[i], 5'(i + 1), 5'(i + 2), 16'h1234, 1'b0, STR_F[i], 5'(i + 10));
      cycle();
      check_val("stream_valid", N'(bus.out_valid), N'(1));
      check_val("stream_a", bus.alu_a, STR_A[i]);
      check_val("stream_b", bus.alu_b, STR_B[i]);
      check_val("stream_f", N'(bus.alu_f), N'(STR_F[i]));
    end

    // Immediate sign extension
    drive_op(32'd3, 32'h5555_5555, 5'd1, 5'd2, 16'h8001, 1'b1, ALU_F_ADD, 5'd3);
    cycle();
    check_val("imm_neg", bus.alu_b, 32'hFFFF_8001);
    drive_op(32'd3, 32'h5555_5555, 5'd1, 5'd2, 16'h7FFF, 1'b1, ALU_F_ADD, 5'd3);
    cycle();
    check_val("imm_pos", bus.alu_b, 32'h0000_7FFF);
    bus.in_valid = 1'b0;
    cycle();

    // Back-pressure: two ops held, third refused until the buffer drains
    bus.out_ready = 1'b0;
    drive_op(32'h11, 32'h0, 5'd1, 5'd1, 16'd0, 1'b0, ALU_F_OR, 5'd1);
    cycle();
    drive_op(32'h22, 32'h0, 5'd1, 5'd1, 16'd0, 1'b0, ALU_F_OR, 5'd2);
    cycle();
    drive_op(32'h33, 32'h0, 5'd1, 5'd1, 16'd0, 1'b0, ALU_F_OR, 5'd3);
    cycle();
    check_val("bp_in_ready", N'(bus.in_ready), N'(0));
    check_val("bp_stall2", N'(bus.stall_cnt), N'(2));
    check_val("bp_head", bus.alu_a, 32'h11);
    cycle();
    check_val("bp_stall3", N'(bus.stall_cnt), N'(3));
    bus.out_ready = 1'b1;
    cycle();
    check_val("bp_op2", bus.alu_a, 32'h22);
    check_val("bp_ready_back", N'(bus.in_ready), N'(1));
    cycle();
    check_val("bp_op3", bus.alu_a, 32'h33);
    bus.in_valid = 1'b0;
    cycle();

    // Forwarding into a held MAIN entry, r0 never bypassed, immediate B untouched
    bus.out_ready = 1'b0;
    drive_op(32'd5, 32'd9, 5'd4, 5'd4, 16'h0010, 1'b1, ALU_F_ADD, 5'd7);
    cycle();
    bus.in_valid = 1'b0;
    set_wb(1'b1, 5'd4, 32'hDEADBEEF);
    cycle();
    check_val("fwd_a", bus.alu_a, EXP_FWD_A);
    check_val("fwd_b_imm", bus.alu_b, 32'h0000_0010);
    set_wb(1'b1, 5'd0, 32'h1234_5678);
    cycle();
    check_val("fwd_r0_a", bus.alu_a, EXP_FWD_A);
    set_wb(1'b0, 5'd0, '0);
    drive_op(32'd1, 32'd2, 5'd6, 5'd3, 16'd0, 1'b0, ALU_F_SUB, 5'd8);
    cycle();
    bus.in_valid = 1'b0;
    set_wb(1'b1, 5'd6, 32'hCAFEF00D);
    bus.out_ready = 1'b1;
    cycle();
    check_val("fwd_skid_move", bus.alu_a, EXP_SKID_A);
    set_wb(1'b0, 5'd0, '0);
    cycle();

    // Random traffic against the model, with one mid-run reset
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 9) < 7) begin
        drive_op($urandom(), $urandom(), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                 16'($urandom()), 1'($urandom_range(0, 1)), 3'($urandom()), 5'($urandom()));
      end else begin
        bus.in_valid = 1'b0;
      end
      set_wb(1'($urandom_range(0, 9) < 4), 5'($urandom_range(0, 7)), $urandom());
      bus.out_ready = ($urandom_range(0, 9) < 7);
      cycle();
      if (i == 1500) async_reset();
    end

    // Saturation of the stall counter
    set_wb(1'b0, 5'd0, '0);
    drive_op(32'hA5, 32'h5A, 5'd1, 5'd2, 16'd0, 1'b0, ALU_F_AND, 5'd9);
    bus.out_ready = 1'b0;
    cycle();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 70000; i++) begin
      @(posedge clk);
      model_edge();
    end
    @(negedge clk);
    check_outputs();
    check_val("stall_sat", N'(bus.stall_cnt), N'(16'hFFFF));
    cycle();
    check_val("stall_hold", N'(bus.stall_cnt), N'(16'hFFFF));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
